// File: rtl/lamp_pkg.sv
// Shared constants and types for the lamp LED status block.
// Holds the duty/direction types and the divider width helper.
package lamp_pkg;

    localparam int c_ms_per_s  = 1000;
    localparam int c_pwm_slots = 256;
    localparam int c_duty_w    = 8;

    typedef logic [c_duty_w-1:0] duty_t;

    typedef enum logic {
        dir_up   = 1'b0,
        dir_down = 1'b1
    } dir_t;

    function automatic int div_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lamp_if.sv
// LED output bundle: the block drives both lines, the board consumes them.
interface lamp_if;

    logic led1;
    logic led2;

    modport master (output led1, output led2);
    modport slave  (input  led1, input  led2);

endinterface

// File: rtl/lamp_tick_div.sv
// Free-running divider: one-cycle tick when the count reaches c_div-1.
module lamp_tick_div
    import lamp_pkg::*;
#(
    parameter int c_div = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int c_w = div_w(c_div);
    localparam logic [c_w-1:0] c_last = c_w'(c_div - 1);

    logic [c_w-1:0] cnt;

    assign o_tick = (cnt == c_last);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (o_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + c_w'(1);
        end
    end

endmodule

// File: rtl/lamp.sv
// Lamp board status LEDs: o_led1 square-wave blink, o_led2 breathing PWM.
module lamp
    import lamp_pkg::*;
#(
    parameter int c_freq     = 12_000_000,
    parameter int c_blink_ms = 250,
    parameter int c_pwm_hz   = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_led1,
    output logic o_led2
);

    localparam int c_ms_raw  = c_freq / c_ms_per_s;
    localparam int c_ms_div  = (c_ms_raw < 1) ? 1 : c_ms_raw;
    localparam int c_pwm_raw = c_freq / (c_pwm_slots * c_pwm_hz);
    localparam int c_pwm_div = (c_pwm_raw < 1) ? 1 : c_pwm_raw;
    localparam int c_bl_w    = div_w(c_blink_ms);
    localparam logic [c_bl_w-1:0] c_bl_last = c_bl_w'(c_blink_ms - 1);

    logic ms_tick;
    logic pwm_tick;

    logic [c_bl_w-1:0] blink_cnt;
    duty_t duty;
    duty_t duty_nxt;
    dir_t  dir;
    dir_t  dir_nxt;
    duty_t slot;

    lamp_tick_div #(.c_div(c_ms_div)) u_ms_div (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (ms_tick)
    );

    lamp_tick_div #(.c_div(c_pwm_div)) u_pwm_div (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (pwm_tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            blink_cnt <= '0;
            o_led1    <= 1'b0;
        end else if (ms_tick) begin
            if (blink_cnt == c_bl_last) begin
                blink_cnt <= '0;
                o_led1    <= ~o_led1;
            end else begin
                blink_cnt <= blink_cnt + c_bl_w'(1);
            end
        end
    end

    // Triangle ramp bounces off 0 and 255 without dwelling at either end.
    always_comb begin
        duty_nxt = duty;
        dir_nxt  = dir;
        if (ms_tick) begin
            unique case (dir)
                dir_up: begin
                    if (duty == 8'hff) begin
                        duty_nxt = 8'hfe;
                        dir_nxt  = dir_down;
                    end else begin
                        duty_nxt = duty + 8'd1;
                    end
                end
                dir_down: begin
                    if (duty == 8'h00) begin
                        duty_nxt = 8'h01;
                        dir_nxt  = dir_up;
                    end else begin
                        duty_nxt = duty - 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            duty <= '0;
            dir  <= dir_up;
        end else begin
            duty <= duty_nxt;
            dir  <= dir_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            slot   <= '0;
            o_led2 <= 1'b0;
        end else begin
            if (pwm_tick) begin
                slot <= slot + 8'd1;
            end
            o_led2 <= (slot < duty);
        end
    end

endmodule

// File: tb/tb_lamp.sv
// Self-checking bench for lamp: cycle-count reference model plus vector table.
module tb_lamp;

    localparam int c_md = 40;
    localparam int c_mp = 3;
    localparam int c_mb = 5;
    localparam int c_fd = 1;
    localparam int c_fp = 1;
    localparam int c_fb = 250;

    logic clk;
    logic i_rst;
    int   k;
    int   total;
    int   bad;

    lamp_if main_if ();
    lamp_if fast_if ();

    lamp #(
        .c_freq     (40_000),
        .c_blink_ms (c_mb),
        .c_pwm_hz   (50)
    ) u_main (
        .i_clk  (clk),
        .i_rst  (i_rst),
        .o_led1 (main_if.led1),
        .o_led2 (main_if.led2)
    );

    lamp #(
        .c_freq     (1000),
        .c_blink_ms (c_fb),
        .c_pwm_hz   (1000)
    ) u_fast (
        .i_clk  (clk),
        .i_rst  (i_rst),
        .o_led1 (fast_if.led1),
        .o_led2 (fast_if.led2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int k;
        int which;
        int led1;
        int duty;
    } vec_t;

    vec_t tbl [12];

    // k = rising edges since reset release; ms ticks done = k / div.
    function automatic int m_led1(input int kk, input int d, input int b);
        return ((kk / d) / b) % 2;
    endfunction

    function automatic int m_duty(input int m);
        int p;
        p = m % 510;
        return (p <= 255) ? p : 510 - p;
    endfunction

    function automatic int m_led2(input int kk, input int d, input int p);
        if (kk == 0) return 0;
        return ((((kk - 1) / p) % 256) < m_duty((kk - 1) / d)) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%0d want=%0d", name, k, act, exp);
        end
    endtask

    task automatic step(input logic rst);
        i_rst = rst;
        @(posedge clk);
        if (rst) k = 0;
        else k++;
        @(negedge clk);
        chk("main_led1", int'(main_if.led1), m_led1(k, c_md, c_mb));
        chk("main_led2", int'(main_if.led2), m_led2(k, c_md, c_mp));
        chk("main_duty", int'(u_main.duty), m_duty(k / c_md));
        chk("fast_led1", int'(fast_if.led1), m_led1(k, c_fd, c_fb));
        chk("fast_led2", int'(fast_if.led2), m_led2(k, c_fd, c_fp));
    endtask

    initial begin
        int n;
        int r;
        total = 0;
        bad   = 0;
        k     = 0;
        i_rst = 1'b1;

        tbl[0]  = '{160,   0, 0, 4};
        tbl[1]  = '{200,   0, 1, 5};
        tbl[2]  = '{4000,  0, 0, 100};
        tbl[3]  = '{10199, 0, 0, 254};
        tbl[4]  = '{10200, 0, 1, 255};
        tbl[5]  = '{10240, 0, 1, 254};
        tbl[6]  = '{20400, 0, 0, 0};
        tbl[7]  = '{20440, 0, 0, 1};
        tbl[8]  = '{249,   1, 0, 249};
        tbl[9]  = '{250,   1, 1, 250};
        tbl[10] = '{499,   1, 1, 11};
        tbl[11] = '{500,   1, 0, 10};

        repeat (10) begin
            step(1'b1);
            chk("rst_led1", int'(main_if.led1), 0);
            chk("rst_led2", int'(main_if.led2), 0);
        end
        chk("rst_duty", int'(u_main.duty), 0);

        step(1'b0);
        chk("rel_led1", int'(main_if.led1), 0);
        chk("rel_led2", int'(main_if.led2), 0);

        for (int c = 2; c <= 20500; c++) begin
            step(1'b0);
            for (int i = 0; i < 12; i++) begin
                if (tbl[i].k == k) begin
                    if (tbl[i].which == 0) begin
                        chk("tbl_main_led1", int'(main_if.led1), tbl[i].led1);
                        chk("tbl_main_duty", int'(u_main.duty), tbl[i].duty);
                    end else begin
                        chk("tbl_fast_led1", int'(fast_if.led1), tbl[i].led1);
                        chk("tbl_fast_duty", int'(u_fast.duty), tbl[i].duty);
                    end
                end
            end
        end

        step(1'b1);
        chk("midrst_led1", int'(main_if.led1), 0);
        repeat (199) step(1'b0);
        chk("midrst_norise", int'(main_if.led1), 0);
        step(1'b0);
        chk("midrst_rise", int'(main_if.led1), 1);

        repeat (8) begin
            n = $urandom_range(2500, 50);
            repeat (n) step(1'b0);
            r = $urandom_range(3, 1);
            repeat (r) step(1'b1);
        end
        repeat (300) step(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
